// File: rtl/switch_debouncer_if.sv
`default_nettype none
// ============================================================================
// switch_debouncer_if : raw switch input and conditioned outputs | Rev 1.0
// ============================================================================
interface switch_debouncer_if;
  logic btn_in;
  logic btn_level;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (
    output btn_in,
    input  btn_level,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output rise_pulse,
    output fall_pulse,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// switch_debouncer : synchronise and debounce a raw switch line | Rev 1.0
// ============================================================================
module switch_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  switch_debouncer_if.slave bus
);

  localparam logic [1:0] c_IDLE_LOW  = 2'd0;
  localparam logic [1:0] c_WAIT_HIGH = 2'd1;
  localparam logic [1:0] c_IDLE_HIGH = 2'd2;
  localparam logic [1:0] c_WAIT_LOW  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] c_TARGET   = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam bit                   c_ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("switch_debouncer: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 1 ||
      64'(DEBOUNCE_CYCLES) > ((64'(1) << CNT_WIDTH) - 64'(1))) begin : g_bad_cycles
    $error("switch_debouncer: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
  end

  // The state register itself acts as the last synchroniser stage: the FSM
  // decides on the value entering that stage, giving sync latency SYNC_STAGES-1.
  logic [SYNC_STAGES-2:0] sync_q, sync_d;
  logic                   sync_w;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 busy_q, busy_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.btn_in;
    for (int i = 1; i < SYNC_STAGES - 1; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= c_IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_IDLE_LOW: begin
        cnt_d = '0;
        if (sync_w) begin
          if (c_ONE_SHOT) begin
            state_d = c_IDLE_HIGH;
          end else begin
            state_d = c_WAIT_HIGH;
            cnt_d   = CNT_WIDTH'(1);
          end
        end
      end
      c_WAIT_HIGH: begin
        if (!sync_w) begin
          state_d = c_IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == c_TARGET) begin
          state_d = c_IDLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      c_IDLE_HIGH: begin
        cnt_d = '0;
        if (!sync_w) begin
          if (c_ONE_SHOT) begin
            state_d = c_IDLE_LOW;
          end else begin
            state_d = c_WAIT_LOW;
            cnt_d   = CNT_WIDTH'(1);
          end
        end
      end
      c_WAIT_LOW: begin
        if (sync_w) begin
          state_d = c_IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == c_TARGET) begin
          state_d = c_IDLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = c_IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    level_d = (state_d == c_IDLE_HIGH) || (state_d == c_WAIT_LOW);
    busy_d  = (state_d == c_WAIT_HIGH) || (state_d == c_WAIT_LOW);
    rise_d  = level_d & ~level_q;
    fall_d  = ~level_d & level_q;
  end

  assign bus.btn_level  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// tb_switch_debouncer : directed checks of debounce timing | Rev 1.0
// ============================================================================
module tb_switch_debouncer;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  switch_debouncer_if bus4 ();
  switch_debouncer_if bus1 ();

  switch_debouncer #(
    .SYNC_STAGES    (2),
    .CNT_WIDTH      (16),
    .DEBOUNCE_CYCLES(4)
  ) u_dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4)
  );

  switch_debouncer #(
    .SYNC_STAGES    (2),
    .CNT_WIDTH      (16),
    .DEBOUNCE_CYCLES(1)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed/expected are packed as {level, rise, fall, busy}.
  task automatic do_reset();
    bus4.btn_in = 1'b0;
    bus1.btn_in = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus4.btn_in = i[0] ? 1'b0 : 1'b1;
      step();
      obs = {bus4.btn_level, bus4.rise_pulse, bus4.fall_pulse, bus4.busy};
      n_tests++;
      if (obs !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset edge %0d: got %b want 0000", i + 1, obs);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] obs, exp;
    do_reset();
    for (int e = 1; e <= 16; e++) begin
      if (e == 10) bus4.btn_in = 1'b1;
      step();
      exp = {e >= 15, e == 15, 1'b0, (e >= 11) && (e <= 14)};
      obs = {bus4.btn_level, bus4.rise_pulse, bus4.fall_pulse, bus4.busy};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL press edge %0d: got %b want %b", e, obs, exp);
      end
    end
  endtask

  task automatic test_release();
    logic [3:0] obs, exp;
    for (int e = 17; e <= 36; e++) begin
      if (e == 30) bus4.btn_in = 1'b0;
      step();
      exp = {e < 35, 1'b0, e == 35, (e >= 31) && (e <= 34)};
      obs = {bus4.btn_level, bus4.rise_pulse, bus4.fall_pulse, bus4.busy};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL release edge %0d: got %b want %b", e, obs, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] obs, exp;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      if (e == 10) bus4.btn_in = 1'b1;
      if (e == 13) bus4.btn_in = 1'b0;
      step();
      exp = {1'b0, 1'b0, 1'b0, (e >= 11) && (e <= 13)};
      obs = {bus4.btn_level, bus4.rise_pulse, bus4.fall_pulse, bus4.busy};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL bounce edge %0d: got %b want %b", e, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_qual();
    logic [3:0] obs, exp;
    do_reset();
    for (int e = 1; e <= 21; e++) begin
      if (e == 10) bus4.btn_in = 1'b1;
      if (e == 13) rst_n = 1'b0;
      if (e == 14) rst_n = 1'b1;
      step();
      exp = {e >= 19, e == 19, 1'b0,
             ((e >= 11) && (e <= 12)) || ((e >= 15) && (e <= 18))};
      obs = {bus4.btn_level, bus4.rise_pulse, bus4.fall_pulse, bus4.busy};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_mid edge %0d: got %b want %b", e, obs, exp);
      end
    end
  endtask

  task automatic test_one_cycle();
    logic [3:0] obs, exp;
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      if (e == 5)  bus1.btn_in = 1'b1;
      if (e == 10) bus1.btn_in = 1'b0;
      step();
      exp = {(e >= 6) && (e < 11), e == 6, e == 11, 1'b0};
      obs = {bus1.btn_level, bus1.rise_pulse, bus1.fall_pulse, bus1.busy};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL one_cycle edge %0d: got %b want %b", e, obs, exp);
      end
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus4.btn_in = 1'b0;
    bus1.btn_in = 1'b0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_reset_mid_qual();
    test_one_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
